// File: rtl/flash_seq_ctrl_if.sv
// rtl/flash_seq_ctrl_if.sv - config, sequencing and counter-side signals of the LED level sequencer
interface flash_seq_ctrl_if #(
  parameter int CNT_W  = 4,
  parameter int SEG_AW = 3
);
  logic                 cfg_we;
  logic [SEG_AW-1:0]    cfg_addr;
  logic [2*CNT_W+1:0]   cfg_wdata;
  logic                 start;
  logic                 flick;
  logic [CNT_W-1:0]     counter_val;
  logic                 enable;
  logic                 upcount;
  logic                 busy;
  logic                 done;
  logic [SEG_AW-1:0]    seg_idx;

  // Host / counter side: loads the table, starts, and feeds the counter value back
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, flick, counter_val,
    input  enable, upcount, busy, done, seg_idx
  );

  // Sequencer side
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, flick, counter_val,
    output enable, upcount, busy, done, seg_idx
  );
endinterface

// File: rtl/flash_seq_ctrl.sv
// rtl/flash_seq_ctrl.sv - segment-table sequencer steering the up/down LED level counter
module flash_seq_ctrl #(
  parameter int CNT_W   = 4,
  parameter int MAX_SEG = 8,
  parameter int SEG_AW  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  flash_seq_ctrl_if.slave  bus
);
  localparam int ENT_W = 2 + 2 * CNT_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    KICK  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [ENT_W-1:0]   table_q [MAX_SEG];
  logic [SEG_AW-1:0]  seg_idx_q;
  logic               dir_up;
  logic               upcount_q;
  logic               busy_q;
  logic               done_q;

  // Fields of the entry currently being executed; the table is frozen while busy
  logic [ENT_W-1:0]   cur;
  logic [CNT_W-1:0]   tgt;
  logic [CNT_W-1:0]   kick_floor;
  logic               kick_en;
  logic               last;
  logic               seg_final;
  logic               kick_req;
  logic               at_tgt;
  logic               at_floor;

  assign cur        = table_q[seg_idx_q];
  assign tgt        = cur[CNT_W-1:0];
  assign kick_floor = cur[2*CNT_W-1:CNT_W];
  assign kick_en    = cur[2*CNT_W];
  assign last       = cur[2*CNT_W+1];
  assign seg_final  = last || (seg_idx_q == SEG_AW'(MAX_SEG - 1));
  assign at_tgt     = (bus.counter_val == tgt);
  assign at_floor   = (bus.counter_val == kick_floor);
  assign kick_req   = bus.flick && dir_up && kick_en && (bus.counter_val > kick_floor);

  // Table load port; writes only land while idle, reset wipes every entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_SEG; i++) begin
        table_q[i] <= '0;
      end
    end else if (bus.cfg_we && (state == IDLE)) begin
      table_q[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      seg_idx_q <= '0;
      dir_up    <= 1'b0;
      upcount_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            seg_idx_q <= '0;
            state     <= SETUP;
            busy_q    <= 1'b1;
            upcount_q <= 1'b0;
          end
        end
        SETUP: begin
          if (tgt > bus.counter_val) begin
            dir_up    <= 1'b1;
            upcount_q <= 1'b1;
            state     <= RUN;
          end else if (tgt < bus.counter_val) begin
            dir_up    <= 1'b0;
            upcount_q <= 1'b0;
            state     <= RUN;
          end else if (seg_final) begin
            state     <= DONE;
            done_q    <= 1'b1;
            upcount_q <= 1'b0;
          end else begin
            seg_idx_q <= seg_idx_q + 1'b1;
            state     <= SETUP;
            upcount_q <= 1'b0;
          end
        end
        RUN: begin
          // A kickback wins over completing the segment in the same cycle
          if (kick_req) begin
            state     <= KICK;
            upcount_q <= 1'b0;
          end else if (at_tgt) begin
            upcount_q <= 1'b0;
            if (seg_final) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              seg_idx_q <= seg_idx_q + 1'b1;
              state     <= SETUP;
            end
          end
        end
        KICK: begin
          // Floor reached: replay the same segment from SETUP, which heads back up
          if (at_floor) begin
            state     <= SETUP;
            upcount_q <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          upcount_q <= 1'b0;
        end
      endcase
    end
  end

  // Step enable looks at the live counter so the level never steps past its goal
  assign bus.enable  = ((state == RUN)  && !at_tgt) ||
                       ((state == KICK) && !at_floor);
  assign bus.upcount = upcount_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.seg_idx = seg_idx_q;

endmodule
